// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory-side and consumer-side signals of the fetch unit.
interface instruction_fetch_if;
  logic imem_req, imem_ack, instr_valid, instr_ready, branch_taken, halt;
  logic [7:0] imem_addr, imem_rdata, instruction, instr_pc, branch_target;
  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid,
    input imem_ack, imem_rdata, instr_ready, branch_taken, branch_target, halt
  );
  modport slave (
    input imem_req, imem_addr, instruction, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target, halt
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer feeding a 2-entry instruction buffer, with branch redirect and halt.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic clk,
  input logic reset,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state;
  logic [7:0] pc, drain_addr;
  logic [15:0] fifo [2];
  logic rd, wr, push, pop;
  logic [1:0] count, count_nxt;
  assign pop = count != 2'd0 && bus.instr_ready && !bus.branch_taken;
  assign push = state == REQ && bus.imem_ack && !bus.branch_taken;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign bus.imem_req = state != IDLE;
  // DRAIN keeps presenting the abandoned address while pc already holds the redirect target
  assign bus.imem_addr = state == DRAIN ? drain_addr : pc;
  assign bus.instr_valid = count != 2'd0;
  assign {bus.instruction, bus.instr_pc} = fifo[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      drain_addr <= '0;
      count <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      count <= bus.branch_taken ? 2'd0 : count_nxt;
      rd <= rd ^ pop;
      wr <= bus.branch_taken ? rd : wr ^ push;
      if (push) fifo[wr] <= {bus.imem_rdata, pc};
      pc <= bus.branch_taken ? bus.branch_target : push ? pc + 8'd1 : pc;
      case (state)
        IDLE: if (count < 2'd2 && !bus.halt && !bus.branch_taken) state <= REQ;
        REQ:
          if (bus.imem_ack) state <= push && count_nxt < 2'd2 && !bus.halt ? REQ : IDLE;
          else if (bus.branch_taken) begin
            state <= DRAIN;
            drain_addr <= pc;
          end
        DRAIN: if (bus.imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
